// File: rtl/rb_window_reader_if.sv
// rb_window_reader_if: vertical column stream from the window reader to its consumer.
interface rb_window_reader_if #(
  parameter int RBS = 4,
  parameter int PIX_W = 8
);
  logic [(RBS-1)*PIX_W-1:0] col_data;
  logic col_valid;
  logic col_ready;
  logic col_last;
  modport master(output col_data, col_valid, col_last, input col_ready);
  modport slave(input col_data, col_valid, col_last, output col_ready);
endinterface

// File: rtl/rb_window_reader.sv
// rb_window_reader: streams rotated RBS-1 row windows column by column and holds off the row writer.
module rb_window_reader #(
  parameter int RBS = 4,
  parameter int RB_DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int SEL_W = 2,
  parameter int PIX_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic row_done_i,
  output logic wr_stall_o,
  output logic rb_rd_en_o,
  output logic [ADDR_W-1:0] rb_rd_addr_o,
  input  logic [RBS*PIX_W-1:0] rb_dout_i,
  rb_window_reader_if.master col,
  output logic busy_o
);
  localparam int LW = (RBS-1)*PIX_W;
  localparam logic [1:0] FILL = 2'd0, RUN = 2'd1, DRAIN = 2'd2, WAIT = 2'd3;
  localparam logic [SEL_W-1:0] WIN = SEL_W'(RBS-1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RB_DEPTH-1);
  logic [1:0] state_q, state_d;
  logic [SEL_W-1:0] filled_q, filled_d, base_q, base_d;
  logic pending_q, pending_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic inflight_q, inflight_last_q;
  logic [LW-1:0] mem_q [2];
  logic [1:0] mem_last_q;
  logic wptr_q, rptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic issue, pop, pass_end, resume, row_inc;
  logic [LW-1:0] lanes;

  assign pop = col.col_valid & col.col_ready;
  // occupancy is taken net of this cycle's pop so a continuously ready sink sees one column per clock
  assign issue = state_q == RUN && (cnt_q - {1'b0, pop} + {1'b0, inflight_q}) < 2'd2;
  assign pass_end = state_q == DRAIN && cnt_q == 2'd0 && !inflight_q;
  assign row_inc = row_done_i && state_q != FILL;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: state_d = filled_q == WIN ? RUN : FILL;
      RUN: state_d = issue && idx_q == LAST ? DRAIN : RUN;
      DRAIN: state_d = !pass_end ? DRAIN : (pending_q || row_done_i) ? RUN : WAIT;
      default: state_d = row_done_i ? RUN : WAIT;
    endcase
  end

  assign resume = state_d == RUN && (state_q == DRAIN || state_q == WAIT);
  assign pending_d = row_inc && !resume ? 1'b1 : resume && !row_inc ? 1'b0 : pending_q;
  assign filled_d = state_q == FILL && row_done_i && filled_q != WIN ? filled_q + 1'b1 : filled_q;
  assign base_d = !pass_end ? base_q : base_q == WIN ? '0 : base_q + 1'b1;
  assign idx_d = issue ? idx_q + 1'b1 : idx_q;
  assign cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    lanes = '0;
    for (int k = 0; k < RBS-1; k++) begin
      lanes[k*PIX_W +: PIX_W] = rb_dout_i[((int'(base_q) + k) % RBS)*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      filled_q <= '0;
      base_q <= '0;
      pending_q <= 1'b0;
      idx_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      mem_last_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      filled_q <= filled_d;
      base_q <= base_d;
      pending_q <= pending_d;
      idx_q <= idx_d;
      inflight_q <= issue;
      inflight_last_q <= issue && idx_q == LAST;
      cnt_q <= cnt_d;
      if (inflight_q) begin
        mem_q[wptr_q] <= lanes;
        mem_last_q[wptr_q] <= inflight_last_q;
        wptr_q <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign rb_rd_en_o = issue;
  assign rb_rd_addr_o = idx_q;
  assign col.col_valid = cnt_q != 2'd0;
  assign col.col_data = mem_q[rptr_q];
  assign col.col_last = col.col_valid & mem_last_q[rptr_q];
  assign busy_o = state_q == RUN || state_q == DRAIN;
  assign wr_stall_o = busy_o & pending_q;
endmodule

// File: tb/tb_rb_window_reader.sv
// tb_rb_window_reader: row-writer/BRAM model driving the reader, with a queue-based column scoreboard.
module tb_rb_window_reader;
  localparam int RBS = 4, RB_DEPTH = 512, ADDR_W = 9, SEL_W = 2, PIX_W = 8;
  localparam int LW = (RBS-1)*PIX_W;
  typedef struct packed {
    logic [LW-1:0] data;
    logic last;
  } col_t;

  logic clk = 1'b0, rst = 1'b1, row_done = 1'b0;
  logic wr_stall, rb_rd_en, busy;
  logic [ADDR_W-1:0] rb_rd_addr;
  logic [RBS*PIX_W-1:0] rb_dout = '0;
  logic [7:0] mem [RBS][RB_DEPTH];
  col_t exp_q[$];
  col_t mon_e;
  int vectors = 0, errors = 0, cyc = 0, row_n = 0, gen = 0, mode = 0, exp_addr = 0, pops = 0;

  rb_window_reader_if #(.RBS(RBS), .PIX_W(PIX_W)) cif();

  rb_window_reader #(.RBS(RBS), .RB_DEPTH(RB_DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .row_done_i(row_done), .wr_stall_o(wr_stall), .rb_rd_en_o(rb_rd_en),
    .rb_rd_addr_o(rb_rd_addr), .rb_dout_i(rb_dout), .col(cif), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rb_rd_en) begin
      for (int i = 0; i < RBS; i++) rb_dout[i*PIX_W +: PIX_W] <= mem[i][rb_rd_addr];
    end
  end

  function automatic logic [7:0] pix(input int g, input int n, input int a);
    logic [1:0] hi;
    logic [5:0] lo;
    hi = n[1:0];
    lo = a[5:0];
    return {hi, lo} ^ 8'((n / 4) * 29) ^ 8'(g * 71);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // writer: waits for the stall to lift, fills the next RB, and books the pass this row completes
  task automatic prep_row();
    int k;
    int p;
    k = 0;
    while (wr_stall && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) check("stall_release", wr_stall, 0);
    for (int a = 0; a < RB_DEPTH; a++) mem[row_n % RBS][a] = pix(gen, row_n, a);
    if (row_n >= RBS-2) begin
      p = row_n - (RBS-2);
      for (int a = 0; a < RB_DEPTH; a++) begin
        col_t c;
        for (int l = 0; l < RBS-1; l++) c.data[l*PIX_W +: PIX_W] = pix(gen, p + l, a);
        c.last = (a == RB_DEPTH-1);
        exp_q.push_back(c);
      end
    end
    row_n++;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1 row_done = 1'b1;
    @(posedge clk);
    #1 row_done = 1'b0;
  endtask

  task automatic wait_busy(output int cb);
    int k;
    k = 0;
    while (!busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("busy_rise", busy, 1);
    cb = cyc;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("drained_queue", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rb_rd_en, 0);
    check({tag, "_rd_addr"}, rb_rd_addr, 0);
    check({tag, "_col_valid"}, cif.col_valid, 0);
    check({tag, "_col_last"}, cif.col_last, 0);
    check({tag, "_col_data"}, cif.col_data, 0);
    check({tag, "_wr_stall"}, wr_stall, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    cif.col_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cif.col_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? ~cif.col_ready : 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) exp_addr = 0;
    else begin
      if (rb_rd_en) begin
        check("rd_addr", rb_rd_addr, exp_addr);
        exp_addr = (exp_addr + 1) % RB_DEPTH;
      end
      if (dut.cnt_q >= 2) begin
        check("fifo_count", dut.cnt_q, 2);
        check("push_into_full", dut.inflight_q && !(cif.col_valid && cif.col_ready), 0);
      end
      if (cif.col_valid && cif.col_ready) begin
        if (exp_q.size() == 0) check("col_count", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          check("col_data", cif.col_data, mon_e.data);
          check("col_last", cif.col_last, mon_e.last);
        end
        pops++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cb, first_v, last_v, nvalid, pstart, k;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    for (int r = 0; r < RBS-1; r++) begin
      prep_row();
      pulse();
      if (r < RBS-2) repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    wait_busy(cb);
    first_v = -1;
    last_v = -1;
    nvalid = 0;
    fork
      begin
        for (int i = 0; i < 516; i++) begin
          if (cif.col_valid) begin
            nvalid++;
            if (first_v < 0) first_v = i;
          end
          if (cif.col_valid && cif.col_last) last_v = i;
          @(negedge clk);
        end
      end
      begin
        repeat (100) @(posedge clk);
        prep_row();
        pulse();
        @(negedge clk);
        check("wr_stall_set", wr_stall, 1);
        while (cyc < cb + 514) @(negedge clk);
        check("wr_stall_held", wr_stall, 1);
        @(negedge clk);
        check("wr_stall_clear", wr_stall, 0);
      end
    join
    check("first_valid_cycle", first_v, 2);
    check("last_valid_cycle", last_v, 513);
    check("valid_cycles", nvalid, 512);
    mode = 1;
    prep_row();
    pulse();
    mode = 2;
    prep_row();
    pulse();
    mode = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 5) check("rd_while_stalled", rb_rd_en, 0);
    end
    check("busy_while_stalled", busy, 1);
    mode = 1;
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      prep_row();
      pulse();
    end
    wait_idle();
    mode = 0;
    prep_row();
    pulse();
    wait_busy(cb);
    prep_row();
    check("simul_no_stall", wr_stall, 0);
    while (cyc < cb + 514) begin
      @(posedge clk);
      #1;
    end
    row_done = 1'b1;
    @(posedge clk);
    #1 row_done = 1'b0;
    @(negedge clk);
    check("simul_busy_kept", busy, 1);
    check("simul_pending_zero", wr_stall, 0);
    @(negedge clk);
    check("simul_gap_valid", cif.col_valid, 0);
    @(negedge clk);
    check("simul_first_valid", cif.col_valid, 1);
    wait_idle();
    prep_row();
    pulse();
    pstart = pops;
    k = 0;
    while (pops - pstart < 200 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("cols_before_reset", pops - pstart, 200);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    gen = 1;
    row_n = 0;
    for (int r = 0; r < RBS-2; r++) begin
      prep_row();
      pulse();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("fill_no_read", rb_rd_en, 0);
      end
      check("fill_not_busy", busy, 0);
    end
    prep_row();
    pulse();
    wait_busy(cb);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
